// File: rtl/branch_resolve_pipe.sv
// Two-stage RV32I branch/jump resolver: S1 captures the op, S2 holds the resolved
// next PC, link value and mispredict flag until ROB writeback accepts it.
module branch_resolve_pipe #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_pred_pc,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_next_pc,
  output logic [WIDTH-1:0] out_link,
  output logic             out_mispredict,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             early_jump,
  output logic [WIDTH-1:0] early_pc,
  output logic [CNTW-1:0]  branch_cnt,
  output logic [CNTW-1:0]  mispredict_cnt
);

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BLT  = 3'd2;
  localparam logic [2:0] OP_BGE  = 3'd3;
  localparam logic [2:0] OP_BLTU = 3'd4;
  localparam logic [2:0] OP_BGEU = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  // Direction of the op; jumps are unconditionally taken.
  function automatic logic branch_cond(input logic [2:0] op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLT:  return sa < sb;
      OP_BGE:  return sa >= sb;
      OP_BLTU: return a < b;
      OP_BGEU: return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  logic             vld_p1;
  logic [2:0]       op_p1;
  logic [WIDTH-1:0] pc_p1;
  logic [WIDTH-1:0] imm_p1;
  logic [WIDTH-1:0] rs1_p1;
  logic [WIDTH-1:0] rs2_p1;
  logic [WIDTH-1:0] pred_p1;
  logic [TAGW-1:0]  tag_p1;

  logic             vld_p2;
  logic [TAGW-1:0]  tag_p2;
  logic             taken_p2;
  logic [WIDTH-1:0] next_pc_p2;
  logic [WIDTH-1:0] link_p2;
  logic             misp_p2;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] seq_p1;
  logic [WIDTH-1:0] tgt_p1;
  logic [WIDTH-1:0] jalr_p1;
  logic             taken_p1;
  logic [WIDTH-1:0] next_pc_p1;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = vld_p1 && s2_adv;
  assign in_ready = !vld_p1 || s2_adv;
  assign accept   = in_valid && in_ready;
  assign xfer     = vld_p2 && out_ready;

  // Stage 0 -> 1: capture the op from the reservation station.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      op_p1   <= '0;
      pc_p1   <= '0;
      imm_p1  <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      pred_p1 <= '0;
      tag_p1  <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      op_p1   <= in_op;
      pc_p1   <= in_pc;
      imm_p1  <= in_imm;
      rs1_p1  <= in_rs1;
      rs2_p1  <= in_rs2;
      pred_p1 <= in_pred_pc;
      tag_p1  <= in_tag;
    end else if (s1_adv) begin
      vld_p1 <= 1'b0;
    end
  end

  assign seq_p1     = pc_p1 + WIDTH'(1);
  assign tgt_p1     = pc_p1 + imm_p1;
  assign jalr_p1    = rs1_p1 + imm_p1;
  assign taken_p1   = branch_cond(op_p1, rs1_p1, rs2_p1);
  assign next_pc_p1 = (op_p1 == OP_JALR) ? jalr_p1 : (taken_p1 ? tgt_p1 : seq_p1);

  // A wrong JAL prediction is already known in S1, independent of S2 stalls.
  assign early_jump = vld_p1 && (op_p1 == OP_JAL) && (tgt_p1 != pred_p1);
  assign early_pc   = tgt_p1;

  // Stage 1 -> 2: register the resolved result for writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2     <= 1'b0;
      tag_p2     <= '0;
      taken_p2   <= 1'b0;
      next_pc_p2 <= '0;
      link_p2    <= '0;
      misp_p2    <= 1'b0;
    end else if (flush) begin
      vld_p2 <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        tag_p2     <= tag_p1;
        taken_p2   <= taken_p1;
        next_pc_p2 <= next_pc_p1;
        link_p2    <= seq_p1;
        misp_p2    <= next_pc_p1 != pred_p1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (xfer && !flush) begin
      branch_cnt <= branch_cnt + CNTW'(1);
      if (misp_p2) mispredict_cnt <= mispredict_cnt + CNTW'(1);
    end
  end

  assign out_valid      = vld_p2;
  assign out_tag        = tag_p2;
  assign out_taken      = taken_p2;
  assign out_next_pc    = next_pc_p2;
  assign out_link       = link_p2;
  assign out_mispredict = misp_p2;
  // Redirect only on an actual handoff; a stalled or flushed result stays silent.
  assign redirect_valid = xfer && misp_p2 && !flush;
  assign redirect_pc    = next_pc_p2;

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Bench for branch_resolve_pipe: directed scenarios plus a randomized stream
// scored against a queue-based reference of the branch/jump rules.
module tb_branch_resolve_pipe;

  localparam int WIDTH = 32;
  localparam int TAGW  = 4;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_pc, in_imm, in_rs1, in_rs2, in_pred_pc;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [TAGW-1:0]  out_tag;
  logic             out_taken;
  logic [WIDTH-1:0] out_next_pc, out_link;
  logic             out_mispredict;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             early_jump;
  logic [WIDTH-1:0] early_pc;
  logic [CNTW-1:0]  branch_cnt, mispredict_cnt;

  branch_resolve_pipe #(.WIDTH(WIDTH), .TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
    .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pred_pc(in_pred_pc),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_taken(out_taken), .out_next_pc(out_next_pc),
    .out_link(out_link), .out_mispredict(out_mispredict),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .early_jump(early_jump), .early_pc(early_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAGW-1:0]  tag;
    logic             taken;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] link;
    logic             misp;
  } res_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_branch = 0;
  int   exp_misp = 0;
  res_t q[$];

  // Reference: RV32I control-flow semantics with word-addressed PCs.
  function automatic res_t model(input logic [2:0] op, input logic [31:0] pc, imm, rs1, rs2,
                                 pred, input logic [3:0] tag);
    res_t r;
    int signed a, b;
    a = rs1;
    b = rs2;
    case (op)
      3'd0: r.taken = (rs1 == rs2);
      3'd1: r.taken = (rs1 != rs2);
      3'd2: r.taken = (a < b);
      3'd3: r.taken = (a >= b);
      3'd4: r.taken = (rs1 < rs2);
      3'd5: r.taken = (rs1 >= rs2);
      default: r.taken = 1'b1;
    endcase
    if (op == 3'd7) r.next_pc = rs1 + imm;
    else r.next_pc = r.taken ? pc + imm : pc + 32'd1;
    r.link = pc + 32'd1;
    r.misp = (r.next_pc != pred);
    r.tag  = tag;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc, imm, rs1,
                       rs2, pred, input logic [3:0] tag);
    in_valid = v; in_op = op; in_pc = pc; in_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_pred_pc = pred; in_tag = tag;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, redirect_valid, early_jump} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000", {out_valid, redirect_valid, early_jump});
    end
    n_cmp++;
    if ({out_next_pc, out_link, early_pc, out_tag} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h %h want 0", out_next_pc, out_link, early_pc, out_tag);
    end
    n_cmp++;
    if ({branch_cnt, mispredict_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_cnt: got %h %h want 0", branch_cnt, mispredict_cnt);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_beq;
    drive(1'b1, 3'd0, 32'h10, 32'h8, 32'd5, 32'd5, 32'h11, 4'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL beq_latency: got %b want 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_taken, out_next_pc, out_mispredict, out_tag} !== {1'b1, 1'b1, 32'h18, 1'b1, 4'd1}) begin
      n_bad++; $display("FAIL beq_result: got v%b t%b pc%h m%b tag%h want v1 t1 pc18 m1 tag1",
                        out_valid, out_taken, out_next_pc, out_mispredict, out_tag);
    end
    n_cmp++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h18}) begin
      n_bad++; $display("FAIL beq_redirect: got %b %h want 1 18", redirect_valid, redirect_pc);
    end
    exp_branch++; exp_misp++;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, redirect_valid} !== 2'b00) begin
      n_bad++; $display("FAIL beq_pulse: got %b want 00", {out_valid, redirect_valid});
    end
    n_cmp++;
    if (mispredict_cnt !== 8'd1 || branch_cnt !== 8'd1) begin
      n_bad++; $display("FAIL beq_cnt: got %0d/%0d want 1/1", branch_cnt, mispredict_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed_unsigned;
    drive(1'b1, 3'd2, 32'h20, 32'h4, 32'hFFFFFFFF, 32'd1, 32'h21, 4'd2);
    @(posedge clk); #1;
    drive(1'b1, 3'd4, 32'h30, 32'h4, 32'hFFFFFFFF, 32'd1, 32'h31, 4'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_tag, out_taken, out_next_pc, out_mispredict} !== {4'd2, 1'b1, 32'h24, 1'b1}) begin
      n_bad++; $display("FAIL blt_signed: got tag%h t%b pc%h m%b want tag2 t1 pc24 m1",
                        out_tag, out_taken, out_next_pc, out_mispredict);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_tag, out_taken, out_next_pc, out_mispredict, redirect_valid} !==
        {1'b1, 4'd3, 1'b0, 32'h31, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL bltu_unsigned: got v%b tag%h t%b pc%h m%b r%b want v1 tag3 t0 pc31 m0 r0",
                        out_valid, out_tag, out_taken, out_next_pc, out_mispredict, redirect_valid);
    end
    exp_branch += 2; exp_misp += 1;
    @(posedge clk); #1;
  endtask

  task automatic test_jal_jalr;
    drive(1'b1, 3'd6, 32'h40, 32'h20, 32'd0, 32'd0, 32'h41, 4'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({early_jump, early_pc} !== {1'b1, 32'h60}) begin
      n_bad++; $display("FAIL jal_early: got %b %h want 1 60", early_jump, early_pc);
    end
    @(posedge clk); #1;
    drive(1'b1, 3'd7, 32'h50, 32'hFFFFFFFF, 32'h100, 32'd0, 32'hFF, 4'd5);
    @(negedge clk);
    n_cmp++;
    if ({out_link, out_next_pc, out_mispredict, out_taken} !== {32'h41, 32'h60, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL jal_result: got link%h pc%h m%b t%b want 41 60 1 1",
                        out_link, out_next_pc, out_mispredict, out_taken);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (early_jump !== 1'b0) begin n_bad++; $display("FAIL jalr_no_early: got %b want 0", early_jump); end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_next_pc, out_mispredict, redirect_valid, out_link, out_taken} !==
        {1'b1, 32'hFF, 1'b0, 1'b0, 32'h51, 1'b1}) begin
      n_bad++; $display("FAIL jalr_result: got v%b pc%h m%b r%b link%h t%b want 1 ff 0 0 51 1",
                        out_valid, out_next_pc, out_mispredict, redirect_valid, out_link, out_taken);
    end
    exp_branch += 2; exp_misp += 1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int first = -1, last = -1, seen = 0;
    res_t got;
    res_t e;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        drive(1'b1, 3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 64)), $urandom,
              $urandom, $urandom, 4'(k));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1 at %0d", in_ready, k); end
      if (out_valid === 1'b1) begin
        if (first < 0) first = k;
        last = k; seen++;
        got = {out_tag, out_taken, out_next_pc, out_link, out_mispredict};
        if (q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL b2b_extra: got tag %h want nothing", out_tag);
        end else begin
          e = q.pop_front();
          n_cmp++;
          if (got !== e) begin n_bad++; $display("FAIL b2b_result: got %h want %h", got, e); end
          n_cmp++;
          if (redirect_valid !== e.misp) begin
            n_bad++; $display("FAIL b2b_redirect: got %b want %b", redirect_valid, e.misp);
          end
          exp_branch++; if (e.misp) exp_misp++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_op, in_pc, in_imm, in_rs1, in_rs2, in_pred_pc, in_tag));
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen != 8 || last - first != 7) begin
      n_bad++; $display("FAIL b2b_stream: got %0d results over %0d cycles want 8 over 8", seen, last - first + 1);
    end
    @(negedge clk);
    n_cmp++;
    if (branch_cnt !== exp_branch[7:0] || mispredict_cnt !== exp_misp[7:0]) begin
      n_bad++; $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", branch_cnt, mispredict_cnt,
                        exp_branch[7:0], exp_misp[7:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 32'h100, 32'h10, 32'd1, 32'd2, 32'h101, 4'd8);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 32'h200, 32'h10, 32'd1, 32'd2, 32'h201, 4'd9);
    @(posedge clk); #1;
    drive(1'b1, 3'd6, 32'h300, 32'h4, 32'd0, 32'd0, 32'h304, 4'd10);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, redirect_valid, out_valid, out_tag, out_next_pc} !== {1'b0, 1'b0, 1'b1, 4'd8, 32'h110}) begin
        n_bad++; $display("FAIL stall_hold: got rdy%b r%b v%b tag%h pc%h want 0 0 1 8 110",
                          in_ready, redirect_valid, out_valid, out_tag, out_next_pc);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({redirect_valid, redirect_pc, in_ready} !== {1'b1, 32'h110, 1'b1}) begin
      n_bad++; $display("FAIL stall_release: got %b %h %b want 1 110 1", redirect_valid, redirect_pc, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_tag, out_next_pc, out_mispredict, redirect_valid} !== {4'd9, 32'h201, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL stall_b: got %h %h %b %b want 9 201 0 0", out_tag, out_next_pc, out_mispredict, redirect_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_tag, out_next_pc, out_mispredict} !== {1'b1, 4'd10, 32'h304, 1'b0}) begin
      n_bad++; $display("FAIL stall_c: got %b %h %h %b want 1 a 304 0", out_valid, out_tag, out_next_pc, out_mispredict);
    end
    exp_branch += 3; exp_misp += 1;
    @(negedge clk);
    n_cmp++;
    if (branch_cnt !== exp_branch[7:0] || mispredict_cnt !== exp_misp[7:0] || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_cnt: got %0d/%0d v%b want %0d/%0d v0", branch_cnt, mispredict_cnt,
                        out_valid, exp_branch[7:0], exp_misp[7:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 32'h500, 32'h10, 32'd3, 32'd3, 32'h501, 4'd1);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 32'h600, 32'h4, 32'd3, 32'd3, 32'h604, 4'd2);
    @(posedge clk); #1;
    drive(1'b1, 3'd6, 32'h700, 32'h4, 32'd0, 32'd0, 32'h0, 4'd3);
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, redirect_valid} !== 2'b10) begin
      n_bad++; $display("FAIL flush_redirect: got v%b r%b want v1 r0", out_valid, redirect_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, redirect_valid, early_jump} !== 3'b000 || branch_cnt !== exp_branch[7:0] ||
          mispredict_cnt !== exp_misp[7:0]) begin
        n_bad++; $display("FAIL flush_drop: got v%b r%b e%b cnt %0d/%0d want 000 %0d/%0d", out_valid,
                          redirect_valid, early_jump, branch_cnt, mispredict_cnt, exp_branch[7:0], exp_misp[7:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    res_t got;
    res_t e;
    logic [31:0] pc, imm, rs1, rs2, pred;
    logic [2:0] op;
    int sel;
    for (int k = 0; k < 420; k++) begin
      if (k < 400) begin
        op  = 3'($urandom_range(0, 7));
        pc  = $urandom;
        imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom;
        rs1 = $urandom;
        rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
        e   = model(op, pc, imm, rs1, rs2, 32'd0, 4'd0);
        sel = $urandom_range(0, 2);
        pred = (sel == 0) ? e.next_pc : (sel == 1) ? pc + 32'd1 : $urandom;
        drive($urandom_range(0, 9) < 7, op, pc, imm, rs1, rs2, pred, 4'($urandom));
        out_ready = ($urandom_range(0, 9) < 7);
        flush = ($urandom_range(0, 99) < 3);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        n_bad++; $display("FAIL rnd_ready: got %b want %b (occupancy %0d)", in_ready,
                          (q.size() < 2) || out_ready, q.size());
      end
      if (out_valid && out_ready && !flush) begin
        got = {out_tag, out_taken, out_next_pc, out_link, out_mispredict};
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra: got tag %h want no result", out_tag);
        end else begin
          e = q.pop_front();
          if (got !== e) begin n_bad++; $display("FAIL rnd_result: got %h want %h", got, e); end
          n_cmp++;
          if ({redirect_valid, redirect_pc} !== {e.misp, e.next_pc}) begin
            n_bad++; $display("FAIL rnd_redirect: got %b %h want %b %h", redirect_valid, redirect_pc, e.misp, e.next_pc);
          end
          exp_branch++; if (e.misp) exp_misp++;
        end
      end else begin
        n_cmp++;
        if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_idle_redirect: got 1 want 0"); end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_op, in_pc, in_imm, in_rs1, in_rs2, in_pred_pc, in_tag));
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rnd_drain: got %0d pending v%b want 0 v0", q.size(), out_valid);
    end
    n_cmp++;
    if (branch_cnt !== exp_branch[7:0] || mispredict_cnt !== exp_misp[7:0]) begin
      n_bad++; $display("FAIL rnd_cnt: got %0d/%0d want %0d/%0d", branch_cnt, mispredict_cnt,
                        exp_branch[7:0], exp_misp[7:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    int n;
    out_ready = 1'b1; flush = 1'b0;
    drive(1'b1, 3'd1, 32'hFFFFFFFF, 32'h5, 32'd7, 32'd7, 32'h0, 4'd6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_link, out_next_pc, out_mispredict, out_taken} !== {1'b1, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL wrap_pc: got v%b link%h pc%h m%b t%b want 1 0 0 0 0",
                        out_valid, out_link, out_next_pc, out_mispredict, out_taken);
    end
    exp_branch++;
    @(posedge clk); #1;
    n = 256 - (exp_branch % 256);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 3'd0, 32'(i), 32'd2, 32'd1, 32'd1, 32'(i + 2), 4'(i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_branch += n;
    n_cmp++;
    if (branch_cnt !== 8'd0 || mispredict_cnt !== exp_misp[7:0]) begin
      n_bad++; $display("FAIL wrap_cnt: got %0d/%0d want 0/%0d", branch_cnt, mispredict_cnt, exp_misp[7:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd6, 32'h800 + 32'(i), 32'h10, 32'd0, 32'd0, 32'h0, 4'(i));
      @(posedge clk); #1;
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, redirect_valid, early_jump, in_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL midreset_ctrl: got %b want 0001", {out_valid, redirect_valid, early_jump, in_ready});
    end
    n_cmp++;
    if ({out_next_pc, out_link, out_tag, early_pc, branch_cnt, mispredict_cnt} !== '0) begin
      n_bad++; $display("FAIL midreset_data: got pc%h link%h tag%h epc%h cnt%0d/%0d want 0",
                        out_next_pc, out_link, out_tag, early_pc, branch_cnt, mispredict_cnt);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    exp_branch = 0; exp_misp = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_jal_jalr();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random();
    test_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_pipe.md
Name: branch_resolve_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle JAL/branch target calculator.
- Resolves all eight RV32I control-flow ops: BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL and JALR.
- Computes the actual next PC and compares it with the front-end prediction. Raises a redirect on mispredict.
- Sits between the branch reservation station (upstream, valid/ready) and ROB writeback (downstream, valid/ready). PCs are word-addressed: the sequential PC is PC+1.

Parameters:
- WIDTH, 32, data and PC width in bits.
- TAGW, 4, ROB tag width.
- CNTW, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill; has priority over all other inputs.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage S1 can accept.
- in_op  in  3  0=BEQ 1=BNE 2=BLT 3=BGE 4=BLTU 5=BGEU 6=JAL 7=JALR.
- in_pc  in  WIDTH  instruction PC.
- in_imm  in  WIDTH  sign-extended immediate, word units.
- in_rs1, in_rs2  in  WIDTH  operand values.
- in_pred_pc  in  WIDTH  predicted next PC.
- in_tag  in  TAGW  ROB tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_tag  out  TAGW  tag of the result.
- out_taken  out  1  actual direction (JAL and JALR are always 1).
- out_next_pc  out  WIDTH  actual next PC.
- out_link  out  WIDTH  PC+1, the rd value for JAL/JALR.
- out_mispredict  out  1  out_next_pc != stored pred_pc.
- redirect_valid  out  1  single-cycle redirect pulse.
- redirect_pc  out  WIDTH  redirect target.
- early_jump  out  1  JAL with a wrong prediction is in S1; combinational from S1 state.
- early_pc  out  WIDTH  JAL target (pc+imm) from S1.
- branch_cnt, mispredict_cnt  out  CNTW  statistics counters.

Behaviour:
- Reset (reset=0, asynchronous): s1_valid=0, s2_valid=0, all S2 data registers 0, counters 0. Consequently out_valid=0, redirect_valid=0, early_jump=0 and all data outputs are 0.
- Two-stage pipeline. The transfer handshake is in_valid&&in_ready. S1 captures the inputs at that edge. At the next advancing edge S2 registers the computed results. out_valid rises 2 cycles after acceptance if the pipeline is not stalled.
- s2_adv = !s2_valid || out_ready.
- s1_adv = s1_valid && s2_adv.
- in_ready = !s1_valid || s2_adv (combinational). This gives full throughput of one op per cycle.
- S1 to S2 computation:
  - seq = pc+1 and tgt = pc+imm, both modulo 2^WIDTH.
  - JALR target = rs1+imm, modulo 2^WIDTH, with no LSB masking.
  - BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - next_pc = taken ? target : seq.
  - mispredict = (next_pc != pred_pc).
- S2 holds all of its registers while out_valid && !out_ready. S1 also holds when S2 cannot advance.
- Redirect:
  - redirect_valid=1 for exactly the cycle in which out_valid && out_ready && out_mispredict; redirect_pc = out_next_pc.
  - A stalled result never pulses redirect_valid.
- early_jump = s1_valid && op==JAL && (pc+imm != pred_pc), regardless of stall. The S2 result for the same op still reports mispredict=1.
- Counters:
  - At each output transfer, branch_cnt increments by 1, and mispredict_cnt increments by 1 if the result mispredicted.
  - Both counters wrap modulo 2^CNTW. Neither is cleared by flush.
- flush=1 at an edge: s1_valid and s2_valid are cleared, and the in_valid transfer in that cycle is discarded.
  - in_ready may still be 1 during the flush cycle, but no data is taken.
  - redirect_valid is forced to 0 during a flush cycle, and the counters do not update.
- Simultaneous events: when S2 drains and S1 advances at the same edge while a new op enters S1, all three moves occur with no bubble.
- Reset asserted mid-operation discards all in-flight ops immediately.

Test Plan:
- Reset, then BEQ pc=0x10, imm=0x8, rs1=rs2=5, pred=0x11 -> 2 cycles later: out_valid=1, taken=1, next_pc=0x18, mispredict=1, redirect_valid for 1 cycle with redirect_pc=0x18, mispredict_cnt=1.
- Signed vs unsigned: BLT with rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken, next_pc=pc+1.
- JAL pc=0x40, imm=0x20, pred=0x41 -> early_jump=1 with early_pc=0x60 one cycle after acceptance; out_link=0x41. JALR rs1=0x100, imm=-1, pred=0xFF -> mispredict=0, no redirect.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 consecutive out_valid cycles, tags in order, branch_cnt=8. Then out_ready=0 for 3 cycles -> outputs stable, in_ready=0 once S1 is full, no redirect pulse while stalled.
- flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0, nothing emitted later, counters unchanged.
- Wrap cases: pc=0xFFFFFFFF gives out_link=0. After 2^CNTW results, branch_cnt returns to 0. Reset asserted between clock edges mid-stream -> outputs 0 immediately.
